multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the CPU datapath (pc, instruction_memory, reg_bank, alu, memory, mux selects).
- Replaces single-cycle combinational control by stepping each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Waits on ready handshakes from instruction and data memory.
- Halts on an illegal opcode or a memory timeout, and counts retired instructions.

Parameters:
- MAX_WAIT, 16, cycles a memory request may wait for ready before timeout (range 1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction[6:0] from instruction register; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction memory read complete.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = pc+4, 1 = branch target.
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
- alu_src  out  1  0 = rb_read2, 1 = imgen_out.
- mem_read  out  1  data memory read enable.
- mem_write  out  1  data memory write enable.
- mem_to_reg  out  1  1 = memory data to register file, 0 = ALU result.
- reg_write  out  1  register file write enable.
- halted  out  1  sticky halt flag.
- fault  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- retired  out  CNT_W  instructions completed.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Moore outputs decode from the state register and the latched opcode op_q.
- Exceptions: ir_write, pc_write and pc_src are asserted in the same cycle imem_ready is sampled high.
- reset low, asynchronous:
  - state=IDLE; op_q=0; wait counter=0; fault=00; retired=0.
  - All outputs 0.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE: op_q<=opcode. Legal opcodes:
  - 0110011 R.
  - 0010011 I-ALU.
  - 0000011 LOAD.
  - 0100011 STORE.
  - 1100011 BRANCH.
  - Any other opcode: next state HALT, fault=01. Otherwise next state EXEC.
- EXEC, by class:
  - R: alu_op=10, alu_src=0.
  - I-ALU: alu_op=10, alu_src=1.
  - LOAD/STORE: alu_op=00, alu_src=1.
  - BRANCH: alu_op=01, alu_src=0, pc_src=1, pc_write=alu_zero.
- EXEC next state:
  - R/I-ALU: WB.
  - LOAD/STORE: MEM.
  - BRANCH: FETCH, and the instruction retires.
- MEM:
  - dmem_req=1, alu_src=1, alu_op=00.
  - mem_read=1 for LOAD; mem_write=1 for STORE. Held stable until dmem_ready.
  - On dmem_ready: STORE goes to FETCH and retires; LOAD goes to WB.
- WB:
  - reg_write=1 for exactly one cycle.
  - mem_to_reg=1 for LOAD, 0 for R/I-ALU.
  - Next state FETCH; the instruction retires.
- Retire: retired increments by 1 on the clock edge leaving WB, STORE-MEM, or BRANCH-EXEC. Wraps modulo 2^CNT_W.
- Timeout counter:
  - Clears on entry to FETCH or MEM; increments each cycle the relevant ready is low.
  - If it reaches MAX_WAIT with ready still low: next state HALT, fault=10 from FETCH or 11 from MEM.
  - Ready arriving in the same cycle the count reaches MAX_WAIT takes priority; no fault is raised.
- HALT:
  - halted=1; all other control outputs 0.
  - fault and retired hold; the state is left only by reset.
- Reset asserted mid-instruction: immediate return to IDLE with outputs 0. A partial MEM write is abandoned; memory must ignore mem_write=0.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.

Test Plan:
- Reset, imem_ready tied high, opcode=0110011 → state sequence IDLE, FETCH, DECODE, EXEC, WB, FETCH; reg_write high exactly 1 cycle; mem_to_reg=0; retired=1 after 5 cycles.
- LOAD (0000011), dmem_ready delayed 3 cycles → mem_read high 4 cycles in MEM; WB with mem_to_reg=1; retired increments once.
- BRANCH (1100011):
  - alu_zero=1 → EXEC shows pc_write=1, pc_src=1, alu_op=01.
  - alu_zero=0 → pc_write=0.
  - Both cases return to FETCH with retired+1.
- opcode=1111111 → HALT after DECODE; halted=1, fault=01; outputs stay 0 for 20 cycles; retired unchanged.
- imem_ready held low, MAX_WAIT=16 → HALT entered after 16 wait cycles, fault=10. Repeat with ready asserted at cycle 16 → no fault.
- STORE with reset pulsed low during MEM → all outputs 0 asynchronously, state IDLE, retired=0; after reset release, normal fetch resumes.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// waits on memory ready handshakes, halts on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_IMEM    = 2'b10;
  localparam logic [1:0] FAULT_DMEM    = 2'b11;

  // The wait counter holds the number of earlier not-ready cycles, so this value marks the
  // MAX_WAIT-th consecutive cycle without ready.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           state, next_state;
  logic [6:0]       op_q;
  logic [7:0]       wait_cnt;
  logic [1:0]       fault_q, fault_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             wait_expired;
  logic             waiting;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign waiting      = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= 7'd0;
      wait_cnt  <= 8'd0;
      fault_q   <= FAULT_NONE;
      retired_q <= '0;
    end else begin
      state    <= next_state;
      fault_q  <= fault_d;
      // Every state other than FETCH/MEM zeroes the counter, which covers entry to both.
      wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
      if (state == DECODE) begin
        op_q <= opcode;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    fault_d    = fault_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;

    case (state)
      IDLE: begin
        next_state = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end else if (wait_expired) begin
          next_state = HALT;
          fault_d    = FAULT_IMEM;
        end
      end

      DECODE: begin
        if (is_legal(opcode)) begin
          next_state = EXEC;
        end else begin
          next_state = HALT;
          fault_d    = FAULT_ILLEGAL;
        end
      end

      EXEC: begin
        case (op_q)
          OP_R: begin
            alu_op     = 2'b10;
            next_state = WB;
          end
          OP_I: begin
            alu_op     = 2'b10;
            alu_src    = 1'b1;
            next_state = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src    = 1'b1;
            next_state = MEM;
          end
          OP_BRANCH: begin
            alu_op     = 2'b01;
            pc_src     = 1'b1;
            pc_write   = alu_zero;
            retire     = 1'b1;
            next_state = FETCH;
          end
          default: begin
            next_state = HALT;
            fault_d    = FAULT_ILLEGAL;
          end
        endcase
      end

      MEM: begin
        dmem_req  = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (op_q == OP_LOAD);
        mem_write = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_STORE) begin
            retire     = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end else if (wait_expired) begin
          next_state = HALT;
          fault_d    = FAULT_DMEM;
        end
      end

      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        retire     = 1'b1;
        next_state = FETCH;
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven instruction vectors with a retire
// scoreboard, plus hand-written reset, illegal-opcode and timeout sequences.
module tb_multicycle_ctrl;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 32;
  localparam int NV       = 7;

  localparam logic [12:0] M_IMEM_REQ   = 13'h1000;
  localparam logic [12:0] M_DMEM_REQ   = 13'h0800;
  localparam logic [12:0] M_IR_WRITE   = 13'h0400;
  localparam logic [12:0] M_PC_WRITE   = 13'h0200;
  localparam logic [12:0] M_PC_SRC     = 13'h0100;
  localparam logic [12:0] M_ALU_SRC    = 13'h0020;
  localparam logic [12:0] M_MEM_READ   = 13'h0010;
  localparam logic [12:0] M_MEM_WRITE  = 13'h0008;
  localparam logic [12:0] M_MEM_TO_REG = 13'h0004;
  localparam logic [12:0] M_REG_WRITE  = 13'h0002;
  localparam logic [12:0] M_HALTED     = 13'h0001;

  localparam logic [12:0] CTL_FETCH_WAIT = M_IMEM_REQ;
  localparam logic [12:0] CTL_FETCH_ACK  = M_IMEM_REQ | M_IR_WRITE | M_PC_WRITE;

  typedef enum int {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_ILLEGAL} cls_t;

  typedef struct {
    string      name;
    logic [6:0] opcode;
    logic       alu_zero;
    cls_t       cls;
    int         dmem_delay;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       pc_write;
    logic       pc_src;
    logic       mem_to_reg;
  } vec_t;

  logic             clk;
  logic             reset;
  logic [6:0]       opcode;
  logic             alu_zero, imem_ready, dmem_ready;
  logic             imem_req, dmem_req, ir_write, pc_write, pc_src;
  logic [1:0]       alu_op;
  logic             alu_src, mem_read, mem_write, mem_to_reg, reg_write, halted;
  logic [1:0]       fault;
  logic [CNT_W-1:0] retired;
  logic [12:0]      ctl;

  vec_t vecs [NV];
  vec_t illegal_vec;
  int   sb [$];
  int   issued;
  int   checks;
  int   failures;

  multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .halted(halted), .fault(fault), .retired(retired)
  );

  assign ctl = {imem_req, dmem_req, ir_write, pc_write, pc_src, alu_op, alu_src,
                mem_read, mem_write, mem_to_reg, reg_write, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRetire(input string name);
    int exp;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: retire observed with empty scoreboard, retired=%0d", name, retired);
    end else begin
      exp = sb.pop_front();
      checkOutput({name, "/retired"}, retired, exp);
    end
  endtask

  // Asserts reset mid-cycle, holds it across an edge, then releases into IDLE.
  task automatic doReset(input string tag);
    reset      = 1'b0;
    opcode     = 7'd0;
    alu_zero   = 1'b0;
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    #1;
    checkOutput({tag, "/rst_ctl"}, 32'(ctl), 32'h0);
    checkOutput({tag, "/rst_fault"}, 32'(fault), 32'h0);
    checkOutput({tag, "/rst_retired"}, retired, 32'h0);
    tick();
    reset      = 1'b1;
    imem_ready = 1'b0;
    #1;
    checkOutput({tag, "/idle_ctl"}, 32'(ctl), 32'h0);
    issued = 0;
    sb.delete();
  endtask

  // Runs one instruction starting in FETCH; ends one edge after it retires (back in FETCH).
  task automatic applyStimulus(input vec_t v);
    logic [12:0] exp_exec, exp_mem, exp_wb;
    exp_exec = {5'b0, v.alu_op, 6'b0} | (v.alu_src ? M_ALU_SRC : 13'h0) |
               (v.pc_write ? M_PC_WRITE : 13'h0) | (v.pc_src ? M_PC_SRC : 13'h0);
    exp_mem  = M_DMEM_REQ | M_ALU_SRC |
               ((v.cls == C_LOAD) ? M_MEM_READ : 13'h0) |
               ((v.cls == C_STORE) ? M_MEM_WRITE : 13'h0);
    exp_wb   = M_REG_WRITE | (v.mem_to_reg ? M_MEM_TO_REG : 13'h0);

    imem_ready = 1'b0;
    opcode     = 7'd0;
    #1 checkOutput({v.name, "/fetch_wait"}, 32'(ctl), 32'(CTL_FETCH_WAIT));
    tick();
    imem_ready = 1'b1;
    #1 checkOutput({v.name, "/fetch_ack"}, 32'(ctl), 32'(CTL_FETCH_ACK));
    tick();
    imem_ready = 1'b0;
    opcode     = v.opcode;
    alu_zero   = v.alu_zero;
    #1 checkOutput({v.name, "/decode"}, 32'(ctl), 32'h0);
    if (v.cls != C_ILLEGAL) begin
      issued++;
      sb.push_back(issued);
    end
    tick();
    // The latched opcode must drive EXEC onward, so the bus is spoiled here.
    opcode = 7'h7f;
    if (v.cls == C_ILLEGAL) begin
      for (int i = 0; i < 20; i++) begin
        imem_ready = i[0];
        dmem_ready = ~i[0];
        #1 checkOutput({v.name, "/halt_ctl"}, 32'(ctl), 32'(M_HALTED));
        checkOutput({v.name, "/halt_fault"}, 32'(fault), 32'h1);
        checkOutput({v.name, "/halt_retired"}, retired, 32'(issued));
        tick();
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      return;
    end
    #1 checkOutput({v.name, "/exec"}, 32'(ctl), 32'(exp_exec));
    tick();
    if (v.cls == C_BRANCH) begin
      checkRetire(v.name);
      return;
    end
    if (v.cls == C_LOAD || v.cls == C_STORE) begin
      for (int i = 0; i <= v.dmem_delay; i++) begin
        dmem_ready = (i == v.dmem_delay);
        #1 checkOutput({v.name, "/mem"}, 32'(ctl), 32'(exp_mem));
        tick();
      end
      dmem_ready = 1'b0;
      if (v.cls == C_STORE) begin
        checkRetire(v.name);
        return;
      end
    end
    #1 checkOutput({v.name, "/wb"}, 32'(ctl), 32'(exp_wb));
    tick();
    checkRetire(v.name);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    issued     = 0;
    reset      = 1'b1;
    opcode     = 7'd0;
    alu_zero   = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    vecs[0] = '{name:"r_type",    opcode:7'b0110011, alu_zero:1'b0, cls:C_ALU,    dmem_delay:0,
                alu_op:2'b10, alu_src:1'b0, pc_write:1'b0, pc_src:1'b0, mem_to_reg:1'b0};
    vecs[1] = '{name:"i_alu",     opcode:7'b0010011, alu_zero:1'b0, cls:C_ALU,    dmem_delay:0,
                alu_op:2'b10, alu_src:1'b1, pc_write:1'b0, pc_src:1'b0, mem_to_reg:1'b0};
    vecs[2] = '{name:"load_d3",   opcode:7'b0000011, alu_zero:1'b0, cls:C_LOAD,   dmem_delay:3,
                alu_op:2'b00, alu_src:1'b1, pc_write:1'b0, pc_src:1'b0, mem_to_reg:1'b1};
    vecs[3] = '{name:"store_d0",  opcode:7'b0100011, alu_zero:1'b0, cls:C_STORE,  dmem_delay:0,
                alu_op:2'b00, alu_src:1'b1, pc_write:1'b0, pc_src:1'b0, mem_to_reg:1'b0};
    vecs[4] = '{name:"branch_z1", opcode:7'b1100011, alu_zero:1'b1, cls:C_BRANCH, dmem_delay:0,
                alu_op:2'b01, alu_src:1'b0, pc_write:1'b1, pc_src:1'b1, mem_to_reg:1'b0};
    vecs[5] = '{name:"branch_z0", opcode:7'b1100011, alu_zero:1'b0, cls:C_BRANCH, dmem_delay:0,
                alu_op:2'b01, alu_src:1'b0, pc_write:1'b0, pc_src:1'b1, mem_to_reg:1'b0};
    vecs[6] = '{name:"r_zero",    opcode:7'b0110011, alu_zero:1'b1, cls:C_ALU,    dmem_delay:0,
                alu_op:2'b10, alu_src:1'b0, pc_write:1'b0, pc_src:1'b0, mem_to_reg:1'b0};
    illegal_vec = '{name:"illegal", opcode:7'b1111111, alu_zero:1'b0, cls:C_ILLEGAL, dmem_delay:0,
                    alu_op:2'b00, alu_src:1'b0, pc_write:1'b0, pc_src:1'b0, mem_to_reg:1'b0};

    $display("[TB] starting multicycle_ctrl bench");
    tick();
    doReset("por");
    tick();
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
    end

    // STORE interrupted by reset while waiting in MEM.
    imem_ready = 1'b1;
    #1 checkOutput("st_rst/fetch_ack", 32'(ctl), 32'(CTL_FETCH_ACK));
    tick();
    imem_ready = 1'b0;
    opcode     = 7'b0100011;
    tick();
    #1 checkOutput("st_rst/exec", 32'(ctl), 32'(M_ALU_SRC));
    tick();
    #1 checkOutput("st_rst/mem", 32'(ctl), 32'(M_DMEM_REQ | M_ALU_SRC | M_MEM_WRITE));
    checkOutput("st_rst/retired_before", retired, 32'(NV));
    #2 doReset("st_rst");
    tick();
    applyStimulus(vecs[0]);

    applyStimulus(illegal_vec);

    // Instruction fetch never completes: halt on the MAX_WAIT-th waiting cycle.
    doReset("imem_to");
    tick();
    for (int i = 1; i <= MAX_WAIT; i++) begin
      imem_ready = 1'b0;
      #1 checkOutput($sformatf("imem_to/wait%0d", i), 32'(ctl), 32'(CTL_FETCH_WAIT));
      tick();
    end
    #1 checkOutput("imem_to/halt_ctl", 32'(ctl), 32'(M_HALTED));
    checkOutput("imem_to/fault", 32'(fault), 32'h2);

    // Ready arriving on the final allowed cycle wins over the timeout.
    doReset("imem_late");
    tick();
    for (int i = 1; i < MAX_WAIT; i++) begin
      imem_ready = 1'b0;
      tick();
    end
    imem_ready = 1'b1;
    #1 checkOutput("imem_late/fetch_ack", 32'(ctl), 32'(CTL_FETCH_ACK));
    tick();
    imem_ready = 1'b0;
    opcode     = 7'b0010011;
    #1 checkOutput("imem_late/decode", 32'(ctl), 32'h0);
    checkOutput("imem_late/fault", 32'(fault), 32'h0);
    tick();
    #1 checkOutput("imem_late/exec", 32'(ctl), 32'(13'h0080 | M_ALU_SRC));
    tick();
    #1 checkOutput("imem_late/wb", 32'(ctl), 32'(M_REG_WRITE));
    tick();
    checkOutput("imem_late/retired", retired, 32'h1);

    // Data memory never answers a LOAD.
    doReset("dmem_to");
    tick();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    opcode     = 7'b0000011;
    tick();
    tick();
    for (int i = 1; i <= MAX_WAIT; i++) begin
      dmem_ready = 1'b0;
      #1 checkOutput($sformatf("dmem_to/wait%0d", i), 32'(ctl),
                     32'(M_DMEM_REQ | M_ALU_SRC | M_MEM_READ));
      tick();
    end
    #1 checkOutput("dmem_to/halt_ctl", 32'(ctl), 32'(M_HALTED));
    checkOutput("dmem_to/fault", 32'(fault), 32'h3);
    checkOutput("dmem_to/retired", retired, 32'h0);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
